// File: rtl/sp_window_collect_if.sv
// Sample-in / window-out bundle for sp_window_collect.
// The producer side (master) drives samples and observes windows; the collector uses slave.
interface sp_window_collect_if #(
  parameter int K   = 7,
  parameter int LEN = 16
);
  logic                 in_valid;
  logic [2*LEN-1:0]     in_data;
  logic                 out_valid;
  logic [K*2*LEN-1:0]   out_value;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_value
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_value
  );
endinterface

// File: rtl/sp_window_collect.sv
// Collects complex samples into K-wide windows, in block (hop K) or sliding (hop 1) mode.
// A clr or a change of mode restarts the window; out_value[K-1] is the newest sample.
module sp_window_collect #(
  parameter int K     = 7,
  parameter int LEN   = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  sp_window_collect_if.slave bus,
  input  logic              i_mode,
  input  logic              i_clr,
  output logic [CNT_W-1:0]  o_win_cnt,
  output logic              o_filling
);
  localparam int SW     = 2 * LEN;
  localparam int FILL_W = $clog2(K + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(K);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(K - 1);

  logic [K-1:0][SW-1:0] r_shreg;
  logic [K-1:0][SW-1:0] r_out_value;
  logic                 r_out_valid;
  logic [FILL_W-1:0]    r_fill;
  logic [CNT_W-1:0]     r_win_cnt;
  logic                 r_mode_q;

  logic [K-1:0][SW-1:0] w_shifted;
  logic                 w_mode_chg;
  logic                 w_clear;
  logic                 w_accept;
  logic                 w_emit;
  logic [FILL_W-1:0]    w_fill_next;
  logic [CNT_W-1:0]     w_cnt_next;

  // A mode change restarts the window exactly like clr, but keeps the window count.
  always_comb begin
    w_shifted   = {bus.in_data, r_shreg[K-1:1]};
    w_mode_chg  = (i_mode != r_mode_q);
    w_clear     = i_clr | w_mode_chg;
    w_accept    = bus.in_valid & ~w_clear;
    w_emit      = w_accept & ((r_fill == FILL_LAST) | (r_fill == FILL_FULL));
    w_fill_next = r_fill;
    w_cnt_next  = r_win_cnt;

    if (w_clear) begin
      w_fill_next = '0;
    end else if (w_accept) begin
      if (r_fill == FILL_FULL) begin
        w_fill_next = FILL_FULL;
      end else if (r_fill == FILL_LAST) begin
        w_fill_next = i_mode ? FILL_FULL : '0;
      end else begin
        w_fill_next = r_fill + 1'b1;
      end
    end

    if (i_clr) begin
      w_cnt_next = '0;
    end else if (w_emit) begin
      w_cnt_next = r_win_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_mode_q <= i_mode;
    if (!rst_n) begin
      r_shreg     <= '0;
      r_out_value <= '0;
      r_out_valid <= 1'b0;
      r_fill      <= '0;
      r_win_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_shreg <= w_shifted;
      end
      if (w_emit) begin
        r_out_value <= w_shifted;
      end
      r_out_valid <= w_emit;
      r_fill      <= w_fill_next;
      r_win_cnt   <= w_cnt_next;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_value = r_out_value;
  assign o_win_cnt     = r_win_cnt;
  assign o_filling     = (r_fill < FILL_FULL);
endmodule

// File: tb/tb_sp_window_collect.sv
// Table-driven bench for sp_window_collect with a queue-based window scoreboard.
module tb_sp_window_collect;
  localparam int K     = 7;
  localparam int LEN   = 16;
  localparam int CNT_W = 4;
  localparam int SW    = 2 * LEN;
  localparam int WW    = K * SW;

  typedef struct {
    bit r;
    bit v;
    bit c;
    bit m;
    int n;
    bit ov;
    int cnt;
    bit fil;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic             clr;
  logic [CNT_W-1:0] win_cnt;
  logic             filling;

  sp_window_collect_if #(.K(K), .LEN(LEN)) bus ();

  sp_window_collect #(.K(K), .LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .i_mode    (mode),
    .i_clr     (clr),
    .o_win_cnt (win_cnt),
    .o_filling (filling)
  );

  always #5 clk = ~clk;

  vec_t            tbl[$];
  logic [SW-1:0]   hist[$];
  logic [WW-1:0]   exp_q[$];
  logic [WW-1:0]   last_win;
  bit              prev_mode;
  int              n_checks = 0;
  int              n_pass   = 0;

  function automatic logic [SW-1:0] mk(input int n);
    logic [LEN-1:0] i_part;
    logic [LEN-1:0] q_part;
    i_part = LEN'(n);
    q_part = LEN'(-n);
    return {i_part, q_part};
  endfunction

  function automatic void add(input bit r, input bit v, input bit c, input bit m,
                              input int n, input bit ov, input int cnt, input bit fil);
    vec_t e;
    e = '{r, v, c, m, n, ov, cnt, fil};
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: keeps the samples accepted since the last restart in a queue.
  function automatic void model(input bit r, input bit v, input bit c, input bit m, input int n);
    logic [WW-1:0] w;
    if (r) begin
      hist.delete();
      prev_mode = m;
      return;
    end
    if (c || (m != prev_mode)) begin
      hist.delete();
    end else if (v) begin
      hist.push_back(mk(n));
      if (hist.size() > K) void'(hist.pop_front());
      if (hist.size() == K) begin
        w = '0;
        for (int i = 0; i < K; i++) w[i*SW +: SW] = hist[i];
        exp_q.push_back(w);
        if (!m) hist.delete();
      end
    end
    prev_mode = m;
  endfunction

  task automatic step(input string tag, input bit r, input bit v, input bit c, input bit m,
                      input int n, input bit ov, input int cnt, input bit fil);
    logic [CNT_W-1:0] cnt_exp;
    logic [WW-1:0]    w;
    rst_n        = ~r;
    bus.in_valid = v;
    clr          = c;
    mode         = m;
    bus.in_data  = mk(n);
    model(r, v, c, m, n);
    @(posedge clk);
    #1;
    cnt_exp = cnt[CNT_W-1:0];
    chk({tag, " out_valid"}, WW'(bus.out_valid), WW'(ov));
    chk({tag, " win_cnt"}, WW'(win_cnt), WW'(cnt_exp));
    chk({tag, " filling"}, WW'(filling), WW'(fil));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s window: got %0h with no window expected", tag, bus.out_value);
      end else begin
        w = exp_q.pop_front();
        last_win = w;
        chk({tag, " window"}, bus.out_value, w);
      end
    end
  endtask

  initial begin
    int gaps;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clr          = 1'b0;
    mode         = 1'b0;
    last_win     = '0;
    prev_mode    = 1'b0;

    // Block fill
    for (int n = 1; n <= 14; n++) add(0, 1, 0, 0, n, (n % K) == 0, n / K, 1);
    // Sliding, starting from a clr that also flips mode
    add(0, 0, 1, 1, 0, 0, 0, 1);
    for (int n = 1; n <= 10; n++) add(0, 1, 0, 1, n, n >= K, (n >= K) ? n - 6 : 0, n < K);
    // Gapped block input
    add(0, 0, 1, 0, 0, 0, 0, 1);
    for (int n = 1; n <= K; n++) begin
      gaps = int'($urandom_range(0, 5));
      for (int g = 0; g < gaps; g++) add(0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 0, 0, n, n == K, (n == K) ? 1 : 0, 1);
    end
    // Clear mid-window drops the sample presented with clr
    add(0, 0, 1, 0, 0, 0, 0, 1);
    for (int n = 1; n <= 4; n++) add(0, 1, 0, 0, n, 0, 0, 1);
    add(0, 1, 1, 0, 5, 0, 0, 1);
    for (int n = 6; n <= 12; n++) add(0, 1, 0, 0, n, n == 12, (n == 12) ? 1 : 0, 1);
    // Mode change drops its sample but keeps the count
    add(0, 0, 1, 1, 0, 0, 0, 1);
    for (int n = 1; n <= 9; n++) add(0, 1, 0, 1, n, n >= K, (n >= K) ? n - 6 : 0, n < K);
    add(0, 1, 0, 0, 10, 0, 3, 1);
    for (int n = 11; n <= 17; n++) add(0, 1, 0, 0, n, n == 17, (n == 17) ? 4 : 3, 1);
    // Counter wrap in sliding mode
    add(0, 0, 1, 1, 0, 0, 0, 1);
    for (int n = 1; n <= K + 16; n++)
      add(0, 1, 0, 1, n, n >= K, (n >= K) ? (n - 6) % 16 : 0, n < K);

    step("reset0", 1, 0, 0, 0, 0, 0, 0, 1);
    step("reset1", 1, 1, 0, 0, 9, 0, 0, 1);
    chk("reset out_value", bus.out_value, '0);

    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].m,
           tbl[i].n, tbl[i].ov, tbl[i].cnt, tbl[i].fil);

    // out_value holds the last window through idle cycles
    for (int g = 0; g < 3; g++) step("idle", 0, 0, 0, 1, 0, 0, 1, 0);
    chk("hold out_value", bus.out_value, last_win);

    // Reset mid-stream, then K fresh samples before the next window
    step("midreset", 1, 1, 0, 1, 100, 0, 0, 1);
    chk("midreset out_value", bus.out_value, '0);
    for (int n = 101; n <= 100 + K; n++)
      step("postreset", 0, 1, 0, 1, n, n == 100 + K, (n == 100 + K) ? 1 : 0, n < 100 + K);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d pending windows expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
